video_dsm_dac: RTL and testbench

- Multi-channel first-order delta-sigma 1-bit DAC for composite/NTSC-style video output pins.
- Generalises the single 5-bit video modulator of the board top to C_CH channels of C_W bits, with a built-in pixel clock-enable divider and a registered sample-load handshake.
- Sits between the video generators and the FPGA output pins; runs entirely in the fast system clock domain.

---
 rtl/video_dsm_dac.sv | 146 ++++++++++++++
 tb/tb_video_dsm_dac.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_dsm_dac.sv
// ---------------------------------------------------------------------------
// video_dsm_dac
//
// Multi-channel first-order delta-sigma 1-bit DAC for composite video pins.
// Each channel keeps a (C_W+1)-bit accumulator. Every clock the carry bit
// from the previous sum is dropped and the held sample is added again. The
// carry is the 1-bit output, so a sample D gives exactly D ones in any
// 2^C_W consecutive clocks. A clock-enable divider produces the pixel-rate
// strobe that the video generators use to time their sample loads.
//
// Parameters:
//   C_CH         channel count (1..8)
//   C_W          sample width per channel (1..16)
//   C_DIV        pixel clock-enable divide ratio (2..256)
//   C_ZERO_MUTE  1: a zero sample holds the channel accumulator at zero
//   C_MW         monitor window exponent (window = 2^C_MW clocks)
//
// Ports:
//   CK_i        system clock
//   XARST_i     asynchronous active-low reset
//   SYNC_i      divider phase reset
//   DATs_i      packed samples, channel k at [k*C_W +: C_W]
//   DAT_VLD_i   load strobe for DATs_i
//   CK_EE_o     one-cycle pixel clock-enable pulse
//   DSM_o       1-bit modulator outputs, one per channel
//
// Optional feature, macro VIDEO_DSM_MON_EN (adds a ones-density monitor):
//   MON_SEL_i   channel selected for monitoring
//   MON_CNT_o   ones counted in the last 2^C_MW-clock window
//   MON_VLD_o   one-cycle pulse when MON_CNT_o is updated
// ---------------------------------------------------------------------------
module video_dsm_dac #(
  parameter int C_CH        = 1,
  parameter int C_W         = 5,
  parameter int C_DIV       = 11,
  parameter int C_ZERO_MUTE = 1,
  parameter int C_MW        = 10
) (
  input  logic                                     CK_i,
  input  logic                                     XARST_i,
  input  logic                                     SYNC_i,
  input  logic [C_CH*C_W-1:0]                      DATs_i,
  input  logic                                     DAT_VLD_i,
`ifdef VIDEO_DSM_MON_EN
  input  logic [((C_CH > 1) ? $clog2(C_CH) : 1)-1:0] MON_SEL_i,
  output logic [C_MW:0]                            MON_CNT_o,
  output logic                                     MON_VLD_o,
`endif
  output logic                                     CK_EE_o,
  output logic [C_CH-1:0]                          DSM_o
);

  localparam int DW = $clog2(C_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(C_DIV - 1);

  logic [DW-1:0]       div_ctr;
  logic [C_CH*C_W-1:0] dat_q;

  // CK_EE_o is the registered "counter is at zero" flag, so it is high on
  // the first clock after reset and on the clock after any SYNC_i edge.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      div_ctr <= '0;
      CK_EE_o <= 1'b0;
    end else begin
      CK_EE_o <= (div_ctr == '0);
      if (SYNC_i || (div_ctr == DIV_LAST)) begin
        div_ctr <= '0;
      end else begin
        div_ctr <= div_ctr + DW'(1);
      end
    end
  end

  // The sample register is loaded on the strobe alone. Callers qualify the
  // strobe with CK_EE_o when they want pixel-rate updates.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      dat_q <= '0;
    end else if (DAT_VLD_i) begin
      dat_q <= DATs_i;
    end
  end

  for (genvar k = 0; k < C_CH; k++) begin : g_ch
    logic [C_W:0]   acc;
    logic [C_W-1:0] dat;

    assign dat = dat_q[k*C_W +: C_W];

    // Dropping the previous carry before adding keeps the residue below
    // 2^C_W, so the sum can never overflow. The residue survives sample
    // changes, which avoids a glitch when the sample changes.
    always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
        acc <= '0;
      end else if ((C_ZERO_MUTE != 0) && (dat == '0)) begin
        acc <= '0;
      end else begin
        acc <= {1'b0, acc[C_W-1:0]} + {1'b0, dat};
      end
    end

    assign DSM_o[k] = acc[C_W];
  end

`ifdef VIDEO_DSM_MON_EN
  localparam int SW = (C_CH > 1) ? $clog2(C_CH) : 1;

  logic [C_MW-1:0] wctr;
  logic [C_MW:0]   ones;
  logic            mon_bit;

  // A selection beyond the channel count reads as a constant zero.
  always_comb begin
    mon_bit = 1'b0;
    for (int k = 0; k < C_CH; k++) begin
      if (MON_SEL_i == SW'(k)) begin
        mon_bit = DSM_o[k];
      end
    end
  end

  // The last clock of each window is counted into the published result
  // rather than into the next window.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      wctr      <= '0;
      ones      <= '0;
      MON_CNT_o <= '0;
      MON_VLD_o <= 1'b0;
    end else begin
      wctr <= wctr + C_MW'(1);
      if (&wctr) begin
        MON_CNT_o <= ones + (C_MW+1)'(mon_bit);
        ones      <= '0;
        MON_VLD_o <= 1'b1;
      end else begin
        ones      <= ones + (C_MW+1)'(mon_bit);
        MON_VLD_o <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_video_dsm_dac.sv
// ---------------------------------------------------------------------------
// tb_video_dsm_dac
//
// Bench for video_dsm_dac with 4 channels of 5 bits, divide ratio 11. Two
// instances share the stimulus: one with zero-mute enabled, one without.
// A reference model tracks each channel as an integer residue in
// [0, 2^W): every clock the sample is added and a carry out is a one.
// ---------------------------------------------------------------------------
module tb_video_dsm_dac;

  localparam int CH  = 4;
  localparam int W   = 5;
  localparam int DIV = 11;
  localparam int MW  = 10;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          sync  = 1'b0;
  logic          vld   = 1'b0;
  logic [CH*W-1:0] dats = '0;
  logic          ckee, ckee_nm;
  logic [CH-1:0] dsm, dsm_nm;
`ifdef VIDEO_DSM_MON_EN
  logic [1:0]    mon_sel = 2'd1;
  logic [MW:0]   mon_cnt, mon_cnt_nm;
  logic          mon_vld, mon_vld_nm;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  video_dsm_dac #(.C_CH(CH), .C_W(W), .C_DIV(DIV), .C_ZERO_MUTE(1), .C_MW(MW)) dut (
    .CK_i      (clk),
    .XARST_i   (rst_n),
    .SYNC_i    (sync),
    .DATs_i    (dats),
    .DAT_VLD_i (vld),
`ifdef VIDEO_DSM_MON_EN
    .MON_SEL_i (mon_sel),
    .MON_CNT_o (mon_cnt),
    .MON_VLD_o (mon_vld),
`endif
    .CK_EE_o   (ckee),
    .DSM_o     (dsm)
  );

  video_dsm_dac #(.C_CH(CH), .C_W(W), .C_DIV(DIV), .C_ZERO_MUTE(0), .C_MW(MW)) dut_nm (
    .CK_i      (clk),
    .XARST_i   (rst_n),
    .SYNC_i    (sync),
    .DATs_i    (dats),
    .DAT_VLD_i (vld),
`ifdef VIDEO_DSM_MON_EN
    .MON_SEL_i (mon_sel),
    .MON_CNT_o (mon_cnt_nm),
    .MON_VLD_o (mon_vld_nm),
`endif
    .CK_EE_o   (ckee_nm),
    .DSM_o     (dsm_nm)
  );

  // Reference model: pixel phase plus integer residues per channel.
  int m_phase;
  bit m_ckee;
  int m_datq   [CH];
  int m_res    [CH];
  int m_res_nm [CH];
  bit m_out    [CH];
  bit m_out_nm [CH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_ckee  <= 1'b0;
      for (int k = 0; k < CH; k++) begin
        m_datq[k]   <= 0;
        m_res[k]    <= 0;
        m_res_nm[k] <= 0;
        m_out[k]    <= 1'b0;
        m_out_nm[k] <= 1'b0;
      end
    end else begin
      m_ckee  <= (m_phase == 0);
      m_phase <= sync ? 0 : (m_phase + 1) % DIV;
      for (int k = 0; k < CH; k++) begin
        if (m_datq[k] == 0) begin
          m_res[k] <= 0;
          m_out[k] <= 1'b0;
        end else begin
          m_res[k] <= (m_res[k] + m_datq[k]) % (1 << W);
          m_out[k] <= ((m_res[k] + m_datq[k]) >= (1 << W));
        end
        m_res_nm[k] <= (m_res_nm[k] + m_datq[k]) % (1 << W);
        m_out_nm[k] <= ((m_res_nm[k] + m_datq[k]) >= (1 << W));
        if (vld) m_datq[k] <= int'(dats[k*W +: W]);
      end
    end
  end

  typedef struct packed {
    logic [CH-1:0][W-1:0] dats;
    logic [CH-1:0][5:0]   ones;
  } vec_t;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic checkModel();
    logic [CH-1:0] e, e_nm;
    for (int k = 0; k < CH; k++) begin
      e[k]    = m_out[k];
      e_nm[k] = m_out_nm[k];
    end
    checkOutput("ck_ee_model", int'(ckee), int'(m_ckee));
    checkOutput("dsm_model", int'(dsm), int'(e));
    checkOutput("dsm_nomute_model", int'(dsm_nm), int'(e_nm));
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass,
  // then compare on the following falling edge.
  task automatic applyStimulus(input bit s, input bit v, input logic [CH*W-1:0] d);
    sync = s;
    vld  = v;
    dats = d;
    @(posedge clk);
    @(negedge clk);
    checkModel();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    sync  = 1'b0;
    vld   = 1'b0;
    dats  = '0;
    #1;
    checkOutput("reset_ck_ee", int'(ckee), 0);
    checkOutput("reset_dsm", int'(dsm), 0);
    checkOutput("reset_dsm_nomute", int'(dsm_nm), 0);
`ifdef VIDEO_DSM_MON_EN
    checkOutput("reset_mon_vld", int'(mon_vld), 0);
    checkOutput("reset_mon_cnt", int'(mon_cnt), 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t tbl [5];
    int   pulses;
    int   ones    [CH];
    int   ones_nm [CH];
    logic [CH*W-1:0] rd;

    tbl[0] = '{dats: {5'd24, 5'd16, 5'd8,  5'd0},  ones: {6'd24, 6'd16, 6'd8,  6'd0}};
    tbl[1] = '{dats: {5'd5,  5'd0,  5'd31, 5'd1},  ones: {6'd5,  6'd0,  6'd31, 6'd1}};
    tbl[2] = '{dats: {5'd0,  5'd17, 5'd1,  5'd31}, ones: {6'd0,  6'd17, 6'd1,  6'd31}};
    tbl[3] = '{dats: {5'd2,  5'd30, 5'd16, 5'd16}, ones: {6'd2,  6'd30, 6'd16, 6'd16}};
    tbl[4] = '{dats: {5'd0,  5'd0,  5'd0,  5'd0},  ones: {6'd0,  6'd0,  6'd0,  6'd0}};

    // Divider cadence from reset release.
    doReset();
    pulses = 0;
    for (int i = 1; i <= 1000; i++) begin
      applyStimulus(1'b0, 1'b0, '0);
      if (ckee) pulses++;
      if (i == 1)  checkOutput("ck_ee_first_clock", int'(ckee), 1);
      if (i == 2)  checkOutput("ck_ee_second_clock", int'(ckee), 0);
      if (i == 12) checkOutput("ck_ee_second_pulse", int'(ckee), 1);
    end
    checkOutput("ck_ee_pulses_1000", pulses, 91);

    // SYNC pulse while the divider sits at 5.
    doReset();
    repeat (5) applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("sync_edge_ck_ee", int'(ckee), 0);
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1'b0, 1'b0, '0);
      checkOutput("sync_cadence", int'(ckee), (i == 1 || i == 12) ? 1 : 0);
    end
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 1'b0, '0);
      if (i > 1) checkOutput("sync_held_ck_ee", int'(ckee), 1);
    end
    applyStimulus(1'b0, 1'b0, '0);

    // Table of samples: count ones over the 32 clocks after the load.
    doReset();
    for (int r = 0; r < 5; r++) begin
      applyStimulus(1'b0, 1'b1, tbl[r].dats);
      for (int k = 0; k < CH; k++) begin
        ones[k]    = 0;
        ones_nm[k] = 0;
      end
      for (int c = 0; c < 32; c++) begin
        applyStimulus(1'b0, 1'b0, '0);
        for (int k = 0; k < CH; k++) begin
          ones[k]    += int'(dsm[k]);
          ones_nm[k] += int'(dsm_nm[k]);
        end
      end
      for (int k = 0; k < CH; k++) begin
        checkOutput("density_mute", ones[k], int'(tbl[r].ones[k]));
        checkOutput("density_nomute", ones_nm[k], int'(tbl[r].ones[k]));
      end
    end

    // Asynchronous reset in the middle of full-scale modulation.
    applyStimulus(1'b0, 1'b1, {5'd31, 5'd31, 5'd31, 5'd31});
    repeat (7) applyStimulus(1'b0, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_ck_ee", int'(ckee), 0);
    checkOutput("async_reset_dsm", int'(dsm), 0);
    checkOutput("async_reset_dsm_nomute", int'(dsm_nm), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic against the model.
    doReset();
    for (int i = 0; i < 2000; i++) begin
      rd = CH*W'($urandom);
      for (int k = 0; k < CH; k++) begin
        if ($urandom_range(0, 3) == 0) rd[k*W +: W] = '0;
      end
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, rd);
    end

`ifdef VIDEO_DSM_MON_EN
    // Monitor on channel 1 with a constant sample of 20.
    begin
      int seen;
      int last_t;
      doReset();
      mon_sel = 2'd1;
      applyStimulus(1'b0, 1'b1, {5'd0, 5'd0, 5'd20, 5'd0});
      seen   = 0;
      last_t = 0;
      for (int t = 0; t < 4000 && seen < 3; t++) begin
        applyStimulus(1'b0, 1'b0, '0);
        if (mon_vld) begin
          seen++;
          if (seen >= 2) begin
            checkOutput("mon_cnt", int'(mon_cnt), 640);
            checkOutput("mon_cnt_nomute", int'(mon_cnt_nm), 640);
            checkOutput("mon_period", t - last_t, 1024);
          end
          last_t = t;
        end
      end
      checkOutput("mon_windows_seen", seen, 3);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
